// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider among NREQ requesters.
//
// Each accepted request is loaded into the divider by holding div_reset_n low
// for LOAD_CYC cycles with the operands stable on div_i0/div_i1. The arbiter
// then releases reset and waits for div_ready. The result is returned on the
// resp_* channel, tagged with the requester index. If the divider does not
// finish within TIMEOUT cycles, the operation is aborted with resp_err=1.
// Requesters are served round-robin, and only one operation is in flight.
//
// Optional feature (macro DIV_ZERO_CHECK_EN):
//   A granted request with a zero divisor bypasses the divider. It answers
//   q=all-ones, r=dividend, err=1, and div_reset_n is left untouched.
//
// Handshakes:
//   req/gnt : req[k] is a level and is held until gnt[k] pulses for one cycle.
//             The pulse means the operands of k were captured. A req still
//             high after its gnt counts as a new request.
//   resp    : valid/ready. resp_valid stays high and resp_* stay constant
//             until the cycle where resp_valid && resp_ready. resp_valid
//             drops on the next cycle.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req, req_a, req_b       per-requester request and packed operands
//                           (requester k at [k*WIDTH +: WIDTH])
//   gnt                     one-hot grant pulse
//   resp_valid/ready/id/q/r/err   result channel
//   div_reset_n, div_i0, div_i1   drive the shared divider
//   div_o0, div_o1, div_ready     results from the shared divider
//   dbg_state               current FSM state (IDLE=0, LOAD=1, RUN=2, RESP=3)
module div_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NREQ     = 4,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 64,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_q,
  output logic [WIDTH-1:0]      resp_r,
  output logic                  resp_err,
  output logic                  div_reset_n,
  output logic [WIDTH-1:0]      div_i0,
  output logic [WIDTH-1:0]      div_i1,
  input  logic [WIDTH-1:0]      div_o0,
  input  logic [WIDTH-1:0]      div_o1,
  input  logic                  div_ready,
  output logic [1:0]            dbg_state
);

  localparam int LCW = $clog2(LOAD_CYC + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, RESP = 2'd3} state_t;

  state_t           state;
  logic [IDW-1:0]   rr;
  logic [LCW-1:0]   load_cnt;
  logic [TW-1:0]    timer;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;

  assign dbg_state = state;

  // (base + off) mod NREQ, for off < NREQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  // Pick the first requester at or after the round-robin pointer.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_a     = '0;
    pick_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_valid && req[wrap_idx(rr, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(rr, i);
        pick_a     = req_a[int'(wrap_idx(rr, i))*WIDTH +: WIDTH];
        pick_b     = req_b[int'(wrap_idx(rr, i))*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= '0;
      load_cnt    <= '0;
      timer       <= '0;
      gnt         <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_q      <= '0;
      resp_r      <= '0;
      resp_err    <= 1'b0;
      div_reset_n <= 1'b0;
      div_i0      <= '0;
      div_i1      <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt     <= NREQ'(1) << pick_idx;
            resp_id <= pick_idx;
            rr      <= wrap_idx(pick_idx, 1);
`ifdef DIV_ZERO_CHECK_EN
            if (pick_b == '0) begin
              resp_q     <= '1;
              resp_r     <= pick_a;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else
`endif
            begin
              div_i0      <= pick_a;
              div_i1      <= pick_b;
              div_reset_n <= 1'b0;
              load_cnt    <= '0;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (load_cnt == LCW'(LOAD_CYC - 1)) begin
            div_reset_n <= 1'b1;
            timer       <= '0;
            state       <= RUN;
          end else begin
            load_cnt <= load_cnt + 1'b1;
          end
        end
        RUN: begin
          // During the first RUN cycle, div_ready may still show the
          // completion flag of the previous operation, so it is ignored.
          if (timer != '0 && div_ready) begin
            resp_q     <= div_o0;
            resp_r     <= div_o1;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_q     <= '0;
            resp_r     <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
`timescale 1ns/1ps
module tb_div_arbiter;
  localparam int WIDTH    = 16;
  localparam int NREQ     = 4;
  localparam int LOAD_CYC = 2;
  localparam int TIMEOUT  = 64;
  localparam int IDW      = 2;
  localparam int RW       = 1 + IDW + 2*WIDTH;  // {err, id, q, r}

  // ---------------- clock / reset / DUT ----------------
  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       gnt;
  logic                  resp_valid, resp_ready, resp_err;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_q, resp_r;
  logic                  div_reset_n, div_ready;
  logic [WIDTH-1:0]      div_i0, div_i1, div_o0, div_o1;
  logic [1:0]            dbg_state;

  always #5 clock = ~clock;

  div_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LOAD_CYC(LOAD_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_q(resp_q),
    .resp_r(resp_r), .resp_err(resp_err), .div_reset_n(div_reset_n), .div_i0(div_i0),
    .div_i1(div_i1), .div_o0(div_o0), .div_o1(div_o1), .div_ready(div_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- divider model ----------------
  // It loads the operands while reset_n is low and keeps a stale ready flag
  // through the first cycle after release. It then runs cur_lat cycles before
  // raising ready; with div_hang set it never raises ready.
  logic [WIDTH-1:0] dm_a = '0, dm_b = '0;
  int               dm_cnt = 0, cur_lat = 0, nl;
  logic             dm_started = 1'b0;
  logic             div_hang = 1'b0;
  initial div_ready = 1'b0;

  always @(posedge clock) begin
    if (!div_reset_n) begin
      nl = $urandom_range(0, 20);
      dm_a       <= div_i0;
      dm_b       <= div_i1;
      dm_cnt     <= nl;
      cur_lat    <= nl;
      dm_started <= 1'b0;
    end else if (!dm_started) begin
      dm_started <= 1'b1;
      div_ready  <= 1'b0;
    end else if (dm_cnt > 0) begin
      dm_cnt <= dm_cnt - 1;
    end else if (!div_hang) begin
      div_ready <= 1'b1;
    end
  end
  assign div_o0 = (dm_b != '0) ? dm_a / dm_b : '1;
  assign div_o1 = (dm_b != '0) ? dm_a % dm_b : dm_a;

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  logic [RW-1:0] exp_q[$];
  int gnt_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: grant rule, load window and response timing.
  int               cyc = 0;
  bit               m_idle = 1'b1;
  int               m_rr = 0;
  logic [NREQ-1:0]  exp_gnt = '0;
  int               ld_cnt = 0;
  bit               ld_hi = 1'b0;
  logic [WIDTH-1:0] ld_a, ld_b;
  int               ph = 0;       // 0 none, 1 loading, 2 running, 3 responding
  int               exp_cyc = 0;
  bit               op_hang = 1'b0;

  always @(negedge clock) begin
    int k;
    logic [WIDTH-1:0] a, b;
    logic [RW-1:0] e;
    cyc++;
    if (reset) begin
      m_idle = 1'b1; m_rr = 0; exp_gnt = '0; exp_q.delete();
      ld_cnt = 0; ld_hi = 1'b0; ph = 0;
    end else begin
      check("gnt", gnt, exp_gnt);
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
      if (ld_cnt > 0) begin
        check("div_reset_n_load", div_reset_n, 1'b0);
        check("div_i0", div_i0, ld_a);
        check("div_i1", div_i1, ld_b);
        ld_cnt--;
        if (ld_cnt == 0) ld_hi = 1'b1;
      end else if (ld_hi) begin
        check("div_reset_n_run", div_reset_n, 1'b1);
        ld_hi = 1'b0;
        ph = 2;
        exp_cyc = cyc + (op_hang ? TIMEOUT : cur_lat + 3);
      end
      if (ph == 2 && cyc == exp_cyc) ph = 3;
      check("resp_valid", resp_valid, ph == 3);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q[0];
          check("resp_err", resp_err, e[RW-1]);
          check("resp_id", resp_id, e[2*WIDTH +: IDW]);
          check("resp_q", resp_q, e[WIDTH +: WIDTH]);
          check("resp_r", resp_r, e[0 +: WIDTH]);
        end
      end
      // expectations for the next cycle
      exp_gnt = '0;
      if (m_idle && req != '0) begin
        k = -1;
        for (int i = 0; i < NREQ; i++)
          if (k < 0 && req[(m_rr + i) % NREQ]) k = (m_rr + i) % NREQ;
        exp_gnt = NREQ'(1) << k;
        m_rr = (k + 1) % NREQ;
        m_idle = 1'b0;
        a = req_a[k*WIDTH +: WIDTH];
        b = req_b[k*WIDTH +: WIDTH];
`ifdef DIV_ZERO_CHECK_EN
        if (b == '0) begin
          exp_q.push_back({1'b1, IDW'(k), {WIDTH{1'b1}}, a});
          ph = 3;
        end else
`endif
        begin
          op_hang = div_hang;
          if (div_hang) exp_q.push_back({1'b1, IDW'(k), {WIDTH{1'b0}}, {WIDTH{1'b0}}});
          else          exp_q.push_back({1'b0, IDW'(k), WIDTH'(a / b), WIDTH'(a % b)});
          ld_cnt = LOAD_CYC; ld_a = a; ld_b = b; ph = 1;
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_idle = 1'b1;
        ph = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_ops(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_gnt(input int k);
    int n;
    n = 0;
    while (!gnt[k] && n < 300) begin step(); n++; end
    check("wait_gnt", gnt[k], 1'b1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!resp_valid && n < 300) begin step(); n++; end
    check("wait_valid", resp_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_idle && exp_q.size() == 0) && n < 500) begin step(); n++; end
    check("wait_idle", m_idle && exp_q.size() == 0, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int exp_order[5];
    int n;
    logic [WIDTH-1:0] a, b;
    reset = 1'b1; req = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    step();
    check("rst_gnt", gnt, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_id", resp_id, 0);
    check("rst_q", resp_q, 0);
    check("rst_r", resp_r, 0);
    check("rst_err", resp_err, 0);
    check("rst_div_reset_n", div_reset_n, 0);
    check("rst_div_i0", div_i0, 0);
    check("rst_div_i1", div_i1, 0);
    step(); step();
    reset = 1'b0;
    step();

    // Round robin: all requesting, consumer always ready.
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    for (int k = 0; k < NREQ; k++) set_ops(k, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(1, 300)));
    gnt_log.delete();
    resp_ready = 1'b1;
    req = '1;
    n = 0;
    while (gnt_log.size() < 5 && n < 500) begin step(); n++; end
    req = '0;
    check("rr_count", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++) if (i < gnt_log.size()) check("rr_order", gnt_log[i], exp_order[i]);
    wait_idle();

    // Single operation with literal result, then 10 cycles of backpressure.
    resp_ready = 1'b0;
    set_ops(0, 16'hB0B0, 16'h029A);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_valid();
    check("op_id", resp_id, 0);
    check("op_q", resp_q, 16'h0043);
    check("op_r", resp_r, 16'h0262);
    check("op_err", resp_err, 0);
    set_ops(1, 16'd1000, 16'd7);
    req[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", resp_valid, 1);
      check("bp_gnt", gnt, 0);
      check("bp_q", resp_q, 16'h0043);
      check("bp_r", resp_r, 16'h0262);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_accept_valid", resp_valid, 0);
    check("bp_accept_gnt", gnt, 0);
    step();
    check("bp_next_gnt", gnt, 4'b0010);
    req[1] = 1'b0;
    resp_ready = 1'b1;
    wait_idle();

    // Timeout: divider never finishes.
    div_hang = 1'b1;
    resp_ready = 1'b0;
    set_ops(2, 16'd500, 16'd3);
    req[2] = 1'b1;
    wait_gnt(2);
    req[2] = 1'b0;
    n = 0;
    while (!div_reset_n && n < 100) begin step(); n++; end
    n = 0;
    while (!resp_valid && n < 200) begin step(); n++; end
    check("to_latency", n, TIMEOUT);
    check("to_err", resp_err, 1);
    check("to_q", resp_q, 0);
    check("to_r", resp_r, 0);
    check("to_id", resp_id, 2);
    resp_ready = 1'b1;
    wait_idle();
    div_hang = 1'b0;

`ifdef DIV_ZERO_CHECK_EN
    // Divide by zero bypasses the divider.
    resp_ready = 1'b0;
    set_ops(3, 16'h1234, 16'h0000);
    req[3] = 1'b1;
    wait_gnt(3);
    req[3] = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      check("dz_div_reset_n", div_reset_n, 1);
      step(); n++;
    end
    check("dz_q", resp_q, 16'hFFFF);
    check("dz_r", resp_r, 16'h1234);
    check("dz_err", resp_err, 1);
    resp_ready = 1'b1;
    wait_idle();
`endif

    // Asynchronous reset while in RUN.
    div_hang = 1'b1;
    resp_ready = 1'b0;
    set_ops(1, 16'd900, 16'd9);
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    n = 0;
    while (!div_reset_n && n < 100) begin step(); n++; end
    step(); step(); step();
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", resp_valid, 0);
    check("arst_div_reset_n", div_reset_n, 0);
    check("arst_gnt", gnt, 0);
    div_hang = 1'b0;
    step(); step();
    @(negedge clock);
    #1 reset = 1'b0;
    step();
    resp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) set_ops(k, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(1, 65535)));
    req = '1;
    n = 0;
    while (gnt == '0 && n < 50) begin step(); n++; end
    req = '0;
    check("arst_first_gnt", gnt, 4'b0001);
    wait_idle();

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      step();
      for (int k = 0; k < NREQ; k++) begin
        a = WIDTH'($urandom_range(0, 65535));
        b = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(1, 255)) : WIDTH'($urandom_range(1, 65535));
`ifdef DIV_ZERO_CHECK_EN
        if ($urandom_range(0, 7) == 0) b = '0;
`endif
        if (req[k]) begin
          if (gnt[k]) begin
            if ($urandom_range(0, 3) != 0) req[k] = 1'b0;
            else set_ops(k, a, b);
          end else if ($urandom_range(0, 19) == 0) begin
            req[k] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_ops(k, a, b);
          req[k] = 1'b1;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req = '0;
    resp_ready = 1'b1;
    wait_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
